// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter and busy scoreboard for the 32 x 32-bit register file.
// Two writeback sources (ALU, memory load) compete for the single write port;
// a one-bit round-robin pointer picks the winner and the write is registered
// onto w_en/w_sel/d. A per-register busy vector lets decode stall on operands
// whose writes have not landed yet. R31 reads as zero: never written, never busy.
//
// Handshake (both sources): a transfer happens at a rising edge where
// valid && ready. A source holds sel/data stable while valid is high and not
// yet accepted. ready depends only on reset, the other source's valid and the
// priority pointer -- never on the source's own valid -- so at most one
// transfer occurs per cycle and the loser waits at most one cycle.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_sel,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_sel,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_sel,
  input  logic [4:0]  a_sel,
  input  logic [4:0]  b_sel,
  output logic        a_busy,
  output logic        b_busy,
  output logic        w_en,
  output logic [4:0]  w_sel,
  output logic [31:0] d
);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_t;

  localparam logic [4:0] ZERO_REG = 5'd31;

  prio_t       prio;
  prio_t       prio_nxt;
  logic        alu_xfer;
  logic        mem_xfer;
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  // Grant decode: readies and the resulting transfers for this cycle.
  always_comb begin
    alu_ready = !reset && (!mem_valid || (prio == PRIO_ALU));
    mem_ready = !reset && (!alu_valid || (prio == PRIO_MEM));
    alu_xfer  = alu_valid && alu_ready;
    mem_xfer  = mem_valid && mem_ready;
  end

  // Pointer next state: hand priority to the source that did not win.
  always_comb begin
    prio_nxt = prio;
    if (alu_xfer) begin
      prio_nxt = PRIO_MEM;
    end else if (mem_xfer) begin
      prio_nxt = PRIO_ALU;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PRIO_ALU;
    end else begin
      prio <= prio_nxt;
    end
  end

  // Write stage: register the winning write; a write to R31 is acknowledged
  // but never enabled. With no transfer, select and data hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_en  <= 1'b0;
      w_sel <= 5'd0;
      d     <= 32'd0;
    end else if (alu_xfer) begin
      w_en  <= (alu_sel != ZERO_REG);
      w_sel <= alu_sel;
      d     <= alu_data;
    end else if (mem_xfer) begin
      w_en  <= (mem_sel != ZERO_REG);
      w_sel <= mem_sel;
      d     <= mem_data;
    end else begin
      w_en  <= 1'b0;
    end
  end

  // Scoreboard next state: clear on the landing write, then apply the new
  // reservation so a same-edge reservation of the same register survives.
  always_comb begin
    busy_nxt = busy;
    if (w_en) begin
      busy_nxt[w_sel] = 1'b0;
    end
    if (rsv_en && (rsv_sel != ZERO_REG)) begin
      busy_nxt[rsv_sel] = 1'b1;
    end
    busy_nxt[31] = 1'b0;
  end

  // Scoreboard register; reset drops every reservation.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Operand busy lookups, no bypass.
  always_comb begin
    a_busy = busy[a_sel];
    b_busy = busy[b_sel];
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_sel;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_sel;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic [4:0]  a_sel;
  logic [4:0]  b_sel;
  logic        a_busy;
  logic        b_busy;
  logic        w_en;
  logic [4:0]  w_sel;
  logic [31:0] d;

  int total;
  int bad;

  logic [36:0] exp_q[$];

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .a_sel(a_sel), .b_sel(b_sel), .a_busy(a_busy), .b_busy(b_busy),
    .w_en(w_en), .w_sel(w_sel), .d(d)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_sel = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_sel = 5'd0; mem_data = 32'd0;
    rsv_en = 1'b0; rsv_sel = 5'd0;
  endtask

  task automatic reserve(input logic [4:0] sel);
    rsv_en = 1'b1; rsv_sel = sel;
    tick();
    rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_sel = 5'd2; alu_data = 32'h0000_0011;
    mem_valid = 1'b1; mem_sel = 5'd8; mem_data = 32'h0000_0088;
    a_sel = 5'd2; b_sel = 5'd8;
    tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready: got %b want 0", alu_ready); end
      total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready: got %b want 0", mem_ready); end
      total++; if (w_en !== 1'b0) begin bad++; $display("FAIL rst_w_en: got %b want 0", w_en); end
      total++; if (w_sel !== 5'd0 || d !== 32'd0) begin bad++; $display("FAIL rst_w_sel_d: got %0d/%h want 0/0", w_sel, d); end
      total++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b%b want 00", a_busy, b_busy); end
      if (i == 0) tick();
    end
    reset = 1'b0;
    #1;
    total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin bad++; $display("FAIL rst_first_grant: got %b%b want 10", alu_ready, mem_ready); end
    tick();
    idle();
    #1;
    total++; if (w_en !== 1'b1 || w_sel !== 5'd2 || d !== 32'h0000_0011) begin bad++; $display("FAIL rst_first_write: got %b/%0d/%h want 1/2/00000011", w_en, w_sel, d); end
    tick();
  endtask

  task automatic test_single_alu();
    idle();
    reserve(5'd5);
    alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 32'hDEAD_BEEF;
    a_sel = 5'd5;
    #1;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL alu_busy_set: got %b want 1", a_busy); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    total++; if (w_en !== 1'b1 || w_sel !== 5'd5 || d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_write: got %b/%0d/%h want 1/5/deadbeef", w_en, w_sel, d); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL alu_busy_hold: got %b want 1", a_busy); end
    tick();
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL alu_busy_clear: got %b want 0", a_busy); end
    total++; if (w_en !== 1'b0 || w_sel !== 5'd5 || d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_idle_hold: got %b/%0d/%h want 0/5/deadbeef", w_en, w_sel, d); end
  endtask

  task automatic test_contention();
    int ai;
    int mi;
    int nwr;
    logic ga;
    logic gm;
    logic [36:0] e;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ai = 0; mi = 0; nwr = 0;
    // Expected round-robin order, starting with ALU after reset.
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({5'(1 + k), 32'hA000_0000 + 32'(k)});
      exp_q.push_back({5'(9 + k), 32'hB000_0000 + 32'(k)});
    end
    for (int c = 0; c < 12; c++) begin
      alu_valid = (ai < 4); alu_sel = 5'(1 + ai); alu_data = 32'hA000_0000 + 32'(ai);
      mem_valid = (mi < 4); mem_sel = 5'(9 + mi); mem_data = 32'hB000_0000 + 32'(mi);
      #1;
      ga = alu_valid && alu_ready;
      gm = mem_valid && mem_ready;
      if (ga && gm) begin total++; bad++; $display("FAIL cont_double_grant: got 2 grants want 1 at cycle %0d", c); end
      if (ga) ai++;
      if (gm) mi++;
      tick();
      if (w_en) begin
        nwr++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL cont_extra_write: got sel %0d want none", w_sel);
        end else begin
          e = exp_q.pop_front();
          if ({w_sel, d} !== e) begin bad++; $display("FAIL cont_order: got %0d/%h want %0d/%h", w_sel, d, e[36:32], e[31:0]); end
        end
      end
      if (c == 7) begin
        total++; if (nwr !== 8) begin bad++; $display("FAIL cont_throughput: got %0d writes in 8 cycles want 8", nwr); end
      end
    end
    idle();
    total++; if (exp_q.size() !== 0 || nwr !== 8) begin bad++; $display("FAIL cont_count: got %0d writes, %0d missing want 8, 0", nwr, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_r31();
    idle();
    rsv_en = 1'b1; rsv_sel = 5'd31;
    mem_valid = 1'b1; mem_sel = 5'd31; mem_data = 32'h1234_5678;
    b_sel = 5'd31;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL r31_mem_ready: got %b want 1", mem_ready); end
    tick();
    idle();
    #1;
    total++; if (w_en !== 1'b0) begin bad++; $display("FAIL r31_w_en: got %b want 0", w_en); end
    total++; if (w_sel !== 5'd31 || d !== 32'h1234_5678) begin bad++; $display("FAIL r31_w_sel_d: got %0d/%h want 31/12345678", w_sel, d); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL r31_b_busy: got %b want 0", b_busy); end
    // The discarded MEM transfer still counts as a win, so ALU now has priority.
    alu_valid = 1'b1; mem_valid = 1'b1; alu_sel = 5'd0; mem_sel = 5'd0;
    #1;
    total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin bad++; $display("FAIL r31_prio: got %b%b want 10", alu_ready, mem_ready); end
    idle();
    tick();
  endtask

  task automatic test_collision();
    idle();
    reserve(5'd7);
    alu_valid = 1'b1; alu_sel = 5'd7; alu_data = 32'h0000_0077;
    a_sel = 5'd7;
    tick();
    alu_valid = 1'b0;
    rsv_en = 1'b1; rsv_sel = 5'd7;
    #1;
    total++; if (w_en !== 1'b1 || w_sel !== 5'd7) begin bad++; $display("FAIL coll_pre: got %b/%0d want 1/7", w_en, w_sel); end
    tick();
    rsv_en = 1'b0;
    #1;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL coll_set_wins: got %b want 1", a_busy); end
    tick();
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL coll_still_busy: got %b want 1", a_busy); end
  endtask

  task automatic test_reset_mid();
    idle();
    reserve(5'd20);
    reserve(5'd3);
    alu_valid = 1'b1; alu_sel = 5'd3; alu_data = 32'h0000_0033;
    a_sel = 5'd3; b_sel = 5'd20;
    tick();
    alu_sel = 5'd4; alu_data = 32'h0000_0044;
    reset = 1'b1;
    #1;
    total++; if (w_en !== 1'b1 || w_sel !== 5'd3) begin bad++; $display("FAIL rmid_pre: got %b/%0d want 1/3", w_en, w_sel); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready: got %b want 0", alu_ready); end
    tick();
    reset = 1'b0;
    idle();
    #1;
    total++; if (w_en !== 1'b0) begin bad++; $display("FAIL rmid_w_en: got %b want 0", w_en); end
    total++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b%b want 00", a_busy, b_busy); end
    tick();
  endtask

  // Test sequence and final report
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    a_sel = 5'd0;
    b_sel = 5'd0;
    idle();
    test_reset();
    test_single_alu();
    test_contention();
    test_r31();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
